// File: rtl/tap_controller.sv
// tap_controller: 1149.1 TAP FSM with 2-bit IR, bypass register and DR enable/TDO decode.
module tap_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       bsr_tdo,
  input  logic       scan_tdo,
  input  logic       bist_tdo,
  output logic       TDO,
  output logic       TDO_en,
  output logic [3:0] state,
  output logic [1:0] instruction,
  output logic       shiftLoad,
  output logic       bsr_clkEn,
  output logic       bsr_update,
  output logic       testNorm,
  output logic       scan_clkEn,
  output logic       scan_en,
  output logic       BIST_en
);
  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
    SH_IR = 4'hA, EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } state_t;
  state_t cur, nxt;
  logic [1:0] ir_sh;
  logic byp, sh_dr, dr_act, dr_tdo;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= TLR;
      instruction <= 2'b01;
      ir_sh <= 2'b01;
      byp <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == CAP_IR) ir_sh <= 2'b01;
      else if (cur == SH_IR) ir_sh <= {TDI, ir_sh[1]};
      if (cur == TLR) instruction <= 2'b01;
      else if (cur == UPD_IR) instruction <= ir_sh;
      if (instruction == 2'b01 && cur == CAP_DR) byp <= 1'b0;
      else if (instruction == 2'b01 && cur == SH_DR) byp <= TDI;
    end
  always_comb begin
    nxt = cur;
    case (cur)
      TLR:      nxt = TMS ? TLR    : RTI;
      RTI:      nxt = TMS ? SEL_DR : RTI;
      SEL_DR:   nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:    nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR:   nxt = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR:   nxt = TMS ? SEL_DR : RTI;
      SEL_IR:   nxt = TMS ? TLR    : CAP_IR;
      CAP_IR:   nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:    nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR:   nxt = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR:   nxt = TMS ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
  end
  assign state       = cur;
  assign sh_dr       = cur == SH_DR;
  assign dr_act      = cur == CAP_DR || sh_dr;
  assign TDO_en      = sh_dr || cur == SH_IR;
  assign shiftLoad   = sh_dr;
  assign bsr_clkEn   = dr_act && instruction == 2'b00;
  assign bsr_update  = cur == UPD_DR && instruction == 2'b00;
  assign testNorm    = instruction == 2'b00 && cur != TLR;
  assign scan_clkEn  = dr_act && instruction == 2'b10;
  assign scan_en     = instruction == 2'b10;
  assign BIST_en     = instruction == 2'b11;
  assign dr_tdo      = instruction[1] ? (instruction[0] ? bist_tdo : scan_tdo)
                                      : (instruction[0] ? byp : bsr_tdo);
  assign TDO         = cur == SH_IR ? ir_sh[0] : sh_dr ? dr_tdo : 1'b0;
endmodule

// File: doc/tap_controller.md
# tap_controller

Single-clock IEEE 1149.1-style TAP controller sequencing the team's boundary-scan chain, 2-bit instruction register, bypass register, internal scan chain and BIST engine. It decodes TMS into the 16-state TAP FSM and holds the IR shift and update stages plus a 1-bit bypass register. It produces per-register capture/shift/update enables and mode selects (shiftLoad, testNorm, scan_en, BIST_en), and muxes the selected serial output onto TDO. It sits between the chip test pins and the existing boundaryCell chain and data registers. Those registers are clocked by clk and gated by this block's enables.

## Interface
Parameters: none.
- clk  in  1  test/system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- TMS  in  1  test mode select, sampled on rising clk
- TDI  in  1  test data in
- bsr_tdo  in  1  serial out of boundary register chain
- scan_tdo  in  1  serial out of internal scan chain
- bist_tdo  in  1  serial out of BIST signature register
- TDO  out  1  selected serial out; 0 when TDO_en=0
- TDO_en  out  1  high in Shift-IR or Shift-DR only
- state  out  4  current TAP state (encoding below)
- instruction  out  2  active instruction: 00 boundary, 01 bypass, 10 internal scan, 11 BIST
- shiftLoad  out  1  1 in Shift-DR, else 0 (boundaryCell mux1 select)
- bsr_clkEn  out  1  boundary capture-FF enable: (Capture-DR or Shift-DR) and instruction=00
- bsr_update  out  1  one-cycle pulse in Update-DR when instruction=00
- testNorm  out  1  instruction=00 and state≠Test-Logic-Reset
- scan_clkEn  out  1  (Capture-DR or Shift-DR) and instruction=10
- scan_en  out  1  instruction=10
- BIST_en  out  1  instruction=11

## Operation
- The FSM uses the standard 1149.1 graph and this fixed encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions are per 1149.1 on TMS. SelIR with TMS=1 goes to TLR. UpdIR/UpdDR with TMS=0 go to RTI, with TMS=1 go to SelDR.
- IR shift stage ir_sh[1:0], on the edge while in:
  - CapIR: ir_sh←01.
  - ShIR: ir_sh←{TDI, ir_sh[1]} (LSB shifts out first).
  - UpdIR: instruction←ir_sh.
- TLR forces instruction←01 (bypass) on every edge spent in it.
- Bypass register byp, used when instruction=01: CapDR loads byp←0; ShDR loads byp←TDI.
- TDO mux:
  - ShIR: ir_sh[0].
  - ShDR: instruction 00→bsr_tdo, 01→byp, 10→scan_tdo, 11→bist_tdo.
  - Else 0.
- All outputs are Moore decodes of the state/instruction registers plus the TDO mux (combinational from registers and the *_tdo inputs; no TMS/TDI path).
- Reset values: state=F, instruction=01, ir_sh=01, byp=0.
  - TDO=0, TDO_en=0, shiftLoad=0.
  - bsr_clkEn=0, bsr_update=0, scan_clkEn=0.
  - testNorm=0, scan_en=0, BIST_en=0.

## Timing
- An enable that is high in state S acts on the rising edge that leaves S:
  - Capture occurs on the edge exiting CapDR.
  - Each ShDR cycle shifts exactly one bit.
  - The update FF loads on the edge exiting UpdDR.
- Instruction changes on the edge exiting UpdIR. Decoded modes change the same cycle the new instruction is visible.
- Five consecutive TMS=1 edges from any state reach TLR.
- PauseDR/PauseIR: all enables are low and register contents are held indefinitely. Ex2→Sh resumes shifting without recapture.
- Bypass latency is TDI→TDO of exactly one ShDR clock.
- Async rst mid-shift: state goes immediately to TLR and instruction to 01. Any partial ir_sh content is discarded (reset to 01). No update pulse is emitted.
- Shift with zero cycles (CapDR→Ex1DR directly): capture occurs, no shift, and update still pulses in UpdDR.

## Test plan
- Reset, then rst=0 with TMS=1 for 3 clocks → state=F, instruction=01, TDO_en=0, testNorm=0, all enables 0.
- From TLR, TMS 0,1,1,0,0,0,1,1,0 with TDI=0 during both ShIR cycles:
  - TDO reads 1 then 0 (captured 01).
  - instruction=00 after UpdIR.
  - state=C, testNorm=1.
- instruction=00, walk RTI→SelDR→CapDR→ShDR×4→Ex1DR→UpdDR:
  - bsr_clkEn high for 5 cycles.
  - shiftLoad high only in the 4 ShDR cycles.
  - bsr_update high exactly 1 cycle.
  - TDO follows bsr_tdo only in ShDR.
- Bypass (instruction=01), shift TDI pattern 1,0,1,1 → TDO reads 0,1,0,1 (captured 0, then one-cycle delay).
- Enter PauseDR for 10 cycles mid-shift, then Ex2DR→ShDR → no enables during pause; byp value unchanged; shifting resumes.
- Load instruction=11, assert rst during the next ShDR → same cycle state=F, BIST_en=0, instruction=01; no bsr_update pulse.
